exec_writeback: RTL and testbench

- Commit stage directly downstream of the four execution blocks (arithmetic, logic, left shift, right shift) and upstream of one register-file write port.
- Selects the result and flags of the issuing unit and buffers them in a small in-order queue.
- Drives the RF write port and updates the architectural flags register at commit time.
- Exposes a per-register pending mask so decode can stall on read-after-write hazards.

---
 rtl/exec_wb_pkg.sv | 29 ++
 rtl/exec_wb_if.sv | 42 ++++
 rtl/exec_wb_fifo.sv | 65 ++++++
 rtl/exec_writeback.sv | 118 +++++++++++
 tb/tb_exec_writeback.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/exec_wb_pkg.sv
// Shared types for the execution writeback stage: unit select, flag bit positions
// and the queued commit entry.
package exec_wb_pkg;

    localparam int WB_WORD_WIDTH = 8;
    localparam int WB_ADDR_WIDTH = 3;
    localparam int FLAGS_WIDTH   = 5;

    typedef enum logic [1:0] {
        UNIT_ARITH  = 2'd0,
        UNIT_LOGIC  = 2'd1,
        UNIT_LSHIFT = 2'd2,
        UNIT_RSHIFT = 2'd3
    } unit_sel_e;

    localparam int FLAG_CF = 0;
    localparam int FLAG_ZF = 1;
    localparam int FLAG_OF = 2;
    localparam int FLAG_PF = 3;
    localparam int FLAG_SF = 4;

    typedef struct packed {
        logic [WB_ADDR_WIDTH-1:0] addr;
        logic [WB_WORD_WIDTH-1:0] data;
        logic [FLAGS_WIDTH-1:0]   flags;
        logic                     flags_we;
    } wb_entry_t;

endpackage

// File: rtl/exec_wb_if.sv
// Bundle between the execution units, the writeback stage and the RF write port.
// master = upstream/RF side driving results and stall, slave = writeback stage.
interface exec_wb_if
    import exec_wb_pkg::*;
#(
    parameter int WORD_WIDTH    = WB_WORD_WIDTH,
    parameter int ADDRESS_WIDTH = WB_ADDR_WIDTH
) ();

    logic                     valid_i;
    logic                     ready_o;
    unit_sel_e                unit_sel_i;
    logic [ADDRESS_WIDTH-1:0] dest_i;
    logic                     flags_we_i;
    logic [WORD_WIDTH-1:0]    ab_r_i;
    logic [WORD_WIDTH-1:0]    lb_r_i;
    logic [WORD_WIDTH-1:0]    ls_r_i;
    logic [WORD_WIDTH-1:0]    rs_r_i;
    logic [FLAGS_WIDTH-1:0]   ab_flags_i;
    logic [FLAGS_WIDTH-1:0]   lb_flags_i;
    logic [FLAGS_WIDTH-1:0]   ls_flags_i;
    logic [FLAGS_WIDTH-1:0]   rs_flags_i;
    logic                     stall_i;
    logic                     wr_en_o;
    logic [ADDRESS_WIDTH-1:0] wr_addr_o;
    logic [WORD_WIDTH-1:0]    wr_data_o;

    modport master (
        output valid_i, unit_sel_i, dest_i, flags_we_i,
               ab_r_i, lb_r_i, ls_r_i, rs_r_i,
               ab_flags_i, lb_flags_i, ls_flags_i, rs_flags_i, stall_i,
        input  ready_o, wr_en_o, wr_addr_o, wr_data_o
    );

    modport slave (
        input  valid_i, unit_sel_i, dest_i, flags_we_i,
               ab_r_i, lb_r_i, ls_r_i, rs_r_i,
               ab_flags_i, lb_flags_i, ls_flags_i, rs_flags_i, stall_i,
        output ready_o, wr_en_o, wr_addr_o, wr_data_o
    );

endinterface

// File: rtl/exec_wb_fifo.sv
// In-order queue of writeback entries with occupancy count; no pass-through when full.
// Head entry is read combinationally so the RF port always sees it.
module exec_wb_fifo
    import exec_wb_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk_i,
    input  logic          arst_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  wb_entry_t     push_data_i,
    output wb_entry_t     head_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);

    wb_entry_t     mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
        if (do_push && !do_pop)      count_d = count_q + CW'(1);
        else if (do_pop && !do_push) count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an entry is only visible once count covers it.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/exec_writeback.sv
// Commit stage: selects the issuing unit's result, queues it, writes the RF and
// updates the architectural flags. Optional same-cycle bypass: EXEC_WB_BYPASS_EN.
module exec_writeback
    import exec_wb_pkg::*;
#(
    parameter int WORD_WIDTH    = WB_WORD_WIDTH,
    parameter int ADDRESS_WIDTH = WB_ADDR_WIDTH,
    parameter int DEPTH         = 2
) (
    input  logic                            clk_i,
    input  logic                            arst_i,
    exec_wb_if.slave                        wb,
    output logic [FLAGS_WIDTH-1:0]          flags_o,
    output logic                            cf_o,
    output logic [2**ADDRESS_WIDTH-1:0]     pending_o,
    output logic [$clog2(DEPTH+1)-1:0]      count_o
);

    localparam int CW = $clog2(DEPTH + 1);

    wb_entry_t              push_entry, head_entry, commit_entry;
    logic [WORD_WIDTH-1:0]  res_sel;
    logic [FLAGS_WIDTH-1:0] flg_sel;
    logic                   fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic                   bypass, commit;
    logic [CW-1:0]          fifo_count;
    logic                   ready_en_q, ready_en_d;
    logic [FLAGS_WIDTH-1:0] flags_q, flags_d;

    always_comb begin
        res_sel = wb.ab_r_i;
        flg_sel = wb.ab_flags_i;
        case (wb.unit_sel_i)
            UNIT_ARITH:  begin res_sel = wb.ab_r_i; flg_sel = wb.ab_flags_i; end
            UNIT_LOGIC:  begin res_sel = wb.lb_r_i; flg_sel = wb.lb_flags_i; end
            UNIT_LSHIFT: begin res_sel = wb.ls_r_i; flg_sel = wb.ls_flags_i; end
            UNIT_RSHIFT: begin res_sel = wb.rs_r_i; flg_sel = wb.rs_flags_i; end
        endcase
    end

    assign push_entry = '{addr: wb.dest_i, data: res_sel, flags: flg_sel, flags_we: wb.flags_we_i};

`ifdef EXEC_WB_BYPASS_EN
    // Empty queue and a free RF port: commit straight from the inputs.
    assign bypass       = wb.valid_i && ready_en_q && fifo_empty && !wb.stall_i;
    assign commit_entry = fifo_empty ? push_entry : head_entry;
`else
    assign bypass       = 1'b0;
    assign commit_entry = head_entry;
`endif

    // ready_en_q keeps ready low for the first cycle after reset release.
    assign wb.ready_o = ready_en_q && !fifo_full;
    assign fifo_push  = wb.valid_i && wb.ready_o && !bypass;
    assign fifo_pop   = !fifo_empty && !wb.stall_i;
    assign commit     = fifo_pop || bypass;

    assign wb.wr_en_o   = commit;
    assign wb.wr_addr_o = commit_entry.addr;
    assign wb.wr_data_o = commit_entry.data;

    exec_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i       (clk_i),
        .arst_i      (arst_i),
        .push_i      (fifo_push),
        .pop_i       (fifo_pop),
        .push_data_i (push_entry),
        .head_o      (head_entry),
        .count_o     (fifo_count),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    always_comb begin
        ready_en_d = 1'b1;
        flags_d    = flags_q;
        if (commit && commit_entry.flags_we) flags_d = commit_entry.flags;
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            ready_en_q <= 1'b0;
            flags_q    <= '0;
        end else begin
            ready_en_q <= ready_en_d;
            flags_q    <= flags_d;
        end
    end

    // Per-register count of queued writers; a bit drops when its last writer commits.
    genvar gi;
    generate
        for (gi = 0; gi < 2**ADDRESS_WIDTH; gi++) begin : g_pend
            logic [CW-1:0] cnt_q, cnt_d;
            logic          inc, dec;

            always_comb begin
                inc   = fifo_push && (push_entry.addr == ADDRESS_WIDTH'(gi));
                dec   = fifo_pop && (head_entry.addr == ADDRESS_WIDTH'(gi));
                cnt_d = cnt_q;
                if (inc && !dec)      cnt_d = cnt_q + CW'(1);
                else if (dec && !inc) cnt_d = cnt_q - CW'(1);
            end

            always_ff @(posedge clk_i or posedge arst_i) begin
                if (arst_i) cnt_q <= '0;
                else        cnt_q <= cnt_d;
            end

            assign pending_o[gi] = (cnt_q != '0);
        end
    endgenerate

    assign flags_o = flags_q;
    assign cf_o    = flags_q[FLAG_CF];
    assign count_o = fifo_count;

endmodule

// File: tb/tb_exec_writeback.sv
// Scoreboard bench for exec_writeback: drivers log expected commits into a queue,
// a monitor checks every cycle against a transaction-level model of the queue.
module tb_exec_writeback;
    import exec_wb_pkg::*;

    localparam int DEPTH = 2;

    typedef struct {
        int unsigned stamp;
        logic [2:0]  addr;
        logic [7:0]  data;
        logic [4:0]  flags;
        logic        we;
    } exp_t;

    logic       clk = 1'b0;
    logic       arst = 1'b1;
    logic [4:0] flags;
    logic       cf;
    logic [7:0] pend;
    logic [1:0] cnt;

    exp_t        sb[$];
    logic [4:0]  exp_flags = '0;
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          stall_mode = 0;

    exec_wb_if #(.WORD_WIDTH(8), .ADDRESS_WIDTH(3)) bus ();

    exec_writeback #(.WORD_WIDTH(8), .ADDRESS_WIDTH(3), .DEPTH(DEPTH)) dut (
        .clk_i     (clk),
        .arst_i    (arst),
        .wb        (bus),
        .flags_o   (flags),
        .cf_o      (cf),
        .pending_o (pend),
        .count_o   (cnt)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        case (stall_mode)
            0:       bus.stall_i = 1'b0;
            1:       bus.stall_i = 1'b1;
            default: bus.stall_i = ($urandom_range(0, 3) == 0);
        endcase
    end

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // Monitor: the model counts an entry as queued once the edge after its push has passed.
    initial begin
        int         exp_cnt;
        logic [7:0] ep;
        exp_t       e;
        logic       rdy_ok;
        rdy_ok = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (arst) begin
                chk("rst_count", 32'(cnt), 32'd0);
                chk("rst_wr_en", 32'(bus.wr_en_o), 32'd0);
                chk("rst_pending", 32'(pend), 32'd0);
                chk("rst_flags", 32'(flags), 32'd0);
                chk("rst_ready", 32'(bus.ready_o), 32'd0);
                rdy_ok = 1'b0;
            end else begin
                exp_cnt = 0;
                ep = '0;
                foreach (sb[i]) begin
                    if (sb[i].stamp < cyc) begin
                        exp_cnt++;
                        ep = ep | (8'd1 << sb[i].addr);
                    end
                end
                chk("count", 32'(cnt), 32'(exp_cnt));
                chk("pending", 32'(pend), 32'(ep));
                chk("flags", 32'(flags), 32'(exp_flags));
                chk("cf", 32'(cf), 32'(exp_flags[0]));
                chk("ready", 32'(bus.ready_o), 32'(rdy_ok && (exp_cnt < DEPTH)));
                rdy_ok = 1'b1;
                if (bus.wr_en_o) begin
                    if (sb.size() == 0) begin
                        chk("spurious_wr", 32'(bus.wr_en_o), 32'd0);
                    end else begin
                        e = sb.pop_front();
`ifndef EXEC_WB_BYPASS_EN
                        chk("latency", 32'(e.stamp < cyc), 32'd1);
`endif
                        chk("wr_addr", 32'(bus.wr_addr_o), 32'(e.addr));
                        chk("wr_data", 32'(bus.wr_data_o), 32'(e.data));
                        $display("commit addr=%0d data=%02h we=%0b flags=%05b", e.addr, e.data, e.we, e.flags);
                        if (e.we) exp_flags = e.flags;
                    end
                end else begin
`ifdef EXEC_WB_BYPASS_EN
                    chk("missing_wr", 32'(!bus.stall_i && (sb.size() != 0)), 32'd0);
`else
                    chk("missing_wr", 32'(!bus.stall_i && (exp_cnt != 0)), 32'd0);
`endif
                end
            end
        end
    end

    task automatic send(input int u, input logic [2:0] d, input logic [7:0] val,
                        input logic [4:0] fl, input logic we);
        logic [7:0] r[4];
        logic [4:0] f[4];
        exp_t       e;
        int         n;
        for (int i = 0; i < 4; i++) begin
            r[i] = 8'($urandom);
            f[i] = 5'($urandom);
        end
        r[u] = val;
        f[u] = fl;
        bus.unit_sel_i = unit_sel_e'(u[1:0]);
        bus.dest_i     = d;
        bus.flags_we_i = we;
        bus.ab_r_i = r[0]; bus.lb_r_i = r[1]; bus.ls_r_i = r[2]; bus.rs_r_i = r[3];
        bus.ab_flags_i = f[0]; bus.lb_flags_i = f[1]; bus.ls_flags_i = f[2]; bus.rs_flags_i = f[3];
        bus.valid_i = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (!arst && bus.ready_o) begin
                e.stamp = cyc; e.addr = d; e.data = val; e.flags = fl; e.we = we;
                sb.push_back(e);
                break;
            end
            n++;
            if (n > 300) begin
                n_checks++;
                n_fail++;
                $display("FAIL send_timeout: ready_o got 0 expected 1 (cycle %0d)", cyc);
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 || bus.valid_i) begin
            @(negedge clk);
            #2;
            n++;
            if (n > 300) begin
                n_checks++;
                n_fail++;
                $display("FAIL drain_timeout: queued got %0d expected 0", sb.size());
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        arst = 1'b1;
        sb.delete();
        exp_flags = '0;
        repeat (3) @(posedge clk);
        #2;
        arst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.valid_i = 1'b0; bus.stall_i = 1'b0; bus.dest_i = '0; bus.flags_we_i = 1'b0;
        bus.unit_sel_i = UNIT_ARITH;
        bus.ab_r_i = '0; bus.lb_r_i = '0; bus.ls_r_i = '0; bus.rs_r_i = '0;
        bus.ab_flags_i = '0; bus.lb_flags_i = '0; bus.ls_flags_i = '0; bus.rs_flags_i = '0;
        repeat (3) @(posedge clk);
        #2;
        arst = 1'b0;
        @(posedge clk);
        #1;

        // First commit sets CF and raises/clears pending[3].
        send(0, 3'd3, 8'h5A, 5'b00001, 1'b1);
        wait_idle();

        // Stalled RF: queue fills, third push waits, then drains in order.
        stall_mode = 1;
        repeat (2) @(posedge clk);
        #1;
        fork
            begin
                send(1, 3'd1, 8'h11, 5'b00010, 1'b0);
                send(2, 3'd2, 8'h22, 5'b00100, 1'b0);
                send(3, 3'd4, 8'h33, 5'b01000, 1'b0);
            end
        join_none
        repeat (8) @(posedge clk);
        #1;
        chk("stall_hold_ready", 32'(bus.ready_o), 32'd0);
        chk("stall_hold_count", 32'(cnt), 32'(DEPTH));
        stall_mode = 0;
        wait_idle();

        // Result with flags_we=0 must leave flags untouched.
        send(1, 3'd6, 8'h00, 5'b11110, 1'b0);
        wait_idle();

        // Back-to-back pushes cycling all four units.
        for (int i = 0; i < 8; i++)
            send(i % 4, 3'(i), 8'($urandom), 5'($urandom), 1'b1);
        wait_idle();

        // Reset with two entries queued: both are dropped.
        stall_mode = 1;
        repeat (2) @(posedge clk);
        #1;
        send(0, 3'd7, 8'hA7, 5'b11111, 1'b1);
        send(2, 3'd0, 8'hB0, 5'b10101, 1'b1);
        do_reset();
        stall_mode = 0;
        repeat (3) @(posedge clk);
        #1;

        // Empty queue, rshift result to r5.
        send(3, 3'd5, 8'h81, 5'b10000, 1'b1);
        wait_idle();

        // Randomised traffic with random RF stalls and idle gaps.
        stall_mode = 2;
        for (int i = 0; i < 150; i++) begin
            send(int'($urandom_range(0, 3)), 3'($urandom), 8'($urandom), 5'($urandom), 1'($urandom));
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        stall_mode = 0;
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
